// File: rtl/idu_decode_stage_if.sv
// Fetch->decode->execute handshake bundle for the RV32I decode stage.
// The decode stage is the slave; the fetch/execute side (or bench) is the master.
interface idu_decode_stage_if #(parameter int DATA_WIDTH = 32);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_inst;
  logic [DATA_WIDTH-1:0] in_pc;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_pc;
  logic [DATA_WIDTH-1:0] out_inst;
  logic [4:0]            rs1, rs2, rd;
  logic [DATA_WIDTH-1:0] imm;
  logic [2:0]            imm_type;
  logic [3:0]            op_class;
  logic [2:0]            funct3;
  logic                  funct7_5;
  logic                  reg_write;
  logic                  is_ecall, is_ebreak, is_mret, is_csr;
  logic                  illegal;

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_inst, rs1, rs2, rd, imm, imm_type,
           op_class, funct3, funct7_5, reg_write, is_ecall, is_ebreak, is_mret,
           is_csr, illegal
  );

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, rs1, rs2, rd, imm, imm_type,
           op_class, funct3, funct7_5, reg_write, is_ecall, is_ebreak, is_mret,
           is_csr, illegal
  );
endinterface

// File: rtl/idu_decode_stage.sv
// RV32I + Zicsr decode stage: 2-entry skid buffer (head H, skid S) feeding a
// purely combinational decoder of the head entry.
module idu_decode_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               flush,
  idu_decode_stage_if.slave  bus
);

  typedef struct packed {
    logic                  v;
    logic [DATA_WIDTH-1:0] inst;
    logic [DATA_WIDTH-1:0] pc;
  } entry_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  entry_t h, s;
  logic   accept, consume;

  assign bus.in_ready  = !s.v;
  assign bus.out_valid = h.v;
  assign accept  = bus.in_valid && !s.v;
  assign consume = h.v && bus.out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h <= '0;
      s <= '0;
    end else if (flush) begin
      // a beat accepted alongside flush belongs to the squashed path
      h.v <= 1'b0;
      s.v <= 1'b0;
    end else if (!h.v) begin
      if (accept) h <= '{1'b1, bus.in_inst, bus.in_pc};
    end else if (!s.v) begin
      if (accept && consume) h <= '{1'b1, bus.in_inst, bus.in_pc};
      else if (consume)      h.v <= 1'b0;
      else if (accept)       s <= '{1'b1, bus.in_inst, bus.in_pc};
    end else if (consume) begin
      h   <= s;
      s.v <= 1'b0;
    end
  end

  // Decoder sees zero whenever the head is empty so stale words never leak out.
  logic [DATA_WIDTH-1:0] inst;
  logic [6:0]            opc;
  logic [2:0]            f3;
  logic [6:0]            f7;
  logic [4:0]            rd_f;

  assign inst = h.v ? h.inst : '0;
  assign opc  = inst[6:0];
  assign f3   = inst[14:12];
  assign f7   = inst[31:25];
  assign rd_f = inst[11:7];

  logic [3:0] cls;
  logic [2:0] ityp;
  logic       ill, wr, ecall, ebreak, mret, csr;

  always_comb begin
    cls    = 4'd15;
    ityp   = IMM_NONE;
    ill    = 1'b0;
    wr     = 1'b0;
    ecall  = 1'b0;
    ebreak = 1'b0;
    mret   = 1'b0;
    csr    = 1'b0;
    case (opc)
      OPC_LUI:    begin cls = 4'd0; ityp = IMM_U; wr = 1'b1; end
      OPC_AUIPC:  begin cls = 4'd1; ityp = IMM_U; wr = 1'b1; end
      OPC_JAL:    begin cls = 4'd2; ityp = IMM_J; wr = 1'b1; end
      OPC_JALR:   begin cls = 4'd3; ityp = IMM_I; wr = 1'b1; ill = (f3 != 3'd0); end
      OPC_BRANCH: begin cls = 4'd4; ityp = IMM_B; ill = (f3 == 3'd2) || (f3 == 3'd3); end
      OPC_LOAD:   begin
        cls = 4'd5; ityp = IMM_I; wr = 1'b1;
        ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      OPC_STORE:  begin cls = 4'd6; ityp = IMM_S; ill = (f3 > 3'd2); end
      OPC_OPIMM:  begin cls = 4'd7; ityp = IMM_I; wr = 1'b1; end
      OPC_OP:     begin
        cls = 4'd8; wr = 1'b1;
        ill = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
      end
      OPC_SYSTEM: begin
        cls = 4'd9;
        if (f3 == 3'd0) begin
          ecall  = (inst == DATA_WIDTH'(32'h0000_0073));
          ebreak = (inst == DATA_WIDTH'(32'h0010_0073));
          mret   = (inst == DATA_WIDTH'(32'h3020_0073));
          ill    = !(ecall || ebreak || mret);
        end else if (f3 == 3'd4) begin
          ill = 1'b1;
        end else begin
          // csr address sits in the I-immediate slot
          csr = 1'b1; wr = 1'b1; ityp = IMM_I;
        end
      end
      default: ill = 1'b1;
    endcase
    if (inst[1:0] != 2'b11) ill = 1'b1;
    if (ill) begin
      cls    = 4'd15;
      ityp   = IMM_NONE;
      wr     = 1'b0;
      ecall  = 1'b0;
      ebreak = 1'b0;
      mret   = 1'b0;
      csr    = 1'b0;
    end
    if (rd_f == 5'd0) wr = 1'b0;
  end

  logic [DATA_WIDTH-1:0] imm_v;

  always_comb begin
    imm_v = '0;
    case (ityp)
      IMM_I: imm_v = DATA_WIDTH'($signed(inst[31:20]));
      IMM_S: imm_v = DATA_WIDTH'($signed({inst[31:25], inst[11:7]}));
      IMM_B: imm_v = DATA_WIDTH'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      IMM_U: imm_v = DATA_WIDTH'($signed({inst[31:12], 12'b0}));
      IMM_J: imm_v = DATA_WIDTH'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      default: imm_v = '0;
    endcase
  end

  assign bus.out_inst  = inst;
  assign bus.out_pc    = h.v ? h.pc : '0;
  assign bus.rd        = rd_f;
  assign bus.rs1       = ((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL))
                         ? 5'd0 : inst[19:15];
  assign bus.rs2       = ((opc == OPC_BRANCH) || (opc == OPC_STORE) || (opc == OPC_OP))
                         ? inst[24:20] : 5'd0;
  assign bus.imm       = imm_v;
  assign bus.imm_type  = ityp;
  assign bus.op_class  = cls;
  assign bus.funct3    = f3;
  assign bus.funct7_5  = inst[30];
  assign bus.reg_write = wr;
  assign bus.is_ecall  = ecall;
  assign bus.is_ebreak = ebreak;
  assign bus.is_mret   = mret;
  assign bus.is_csr    = csr;
  assign bus.illegal   = ill;

endmodule

// File: tb/tb_idu_decode_stage.sv
// Directed bench for idu_decode_stage: decode table, backpressure, streaming,
// flush and async reset; inputs driven and outputs sampled on the falling edge.
module tb_idu_decode_stage;
  logic clk = 1'b0;
  logic rstn;
  logic flush;

  idu_decode_stage_if #(.DATA_WIDTH(32)) bus();

  idu_decode_stage #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm;
    logic [2:0]  ityp;
    logic [3:0]  cls;
    logic [4:0]  rd, rs1, rs2;
    logic        rw;
    logic [4:0]  flg;   // {ecall, ebreak, mret, csr, illegal}
    bit          ci;    // compare immediate fields
  } vec_t;

  vec_t vt[11];

  task automatic push(input logic [31:0] inst, input logic [31:0] pc);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_inst  = inst;
    bus.in_pc    = pc;
  endtask

  initial begin
    logic [5:0]  pat;
    logic        pv;
    logic [31:0] pinst;

    vt[0]  = '{32'h0050_0093, 32'h0000_0005, 3'd1, 4'd7,  5'd1,  5'd0, 5'd0, 1'b1, 5'b00000, 1'b1};
    vt[1]  = '{32'hFE00_0EE3, 32'hFFFF_FFFC, 3'd3, 4'd4,  5'd29, 5'd0, 5'd0, 1'b0, 5'b00000, 1'b1};
    vt[2]  = '{32'h0000_006F, 32'h0000_0000, 3'd5, 4'd2,  5'd0,  5'd0, 5'd0, 1'b0, 5'b00000, 1'b1};
    vt[3]  = '{32'h1234_50B7, 32'h1234_5000, 3'd4, 4'd0,  5'd1,  5'd0, 5'd0, 1'b1, 5'b00000, 1'b1};
    vt[4]  = '{32'hFE11_2E23, 32'hFFFF_FFFC, 3'd2, 4'd6,  5'd28, 5'd2, 5'd1, 1'b0, 5'b00000, 1'b1};
    vt[5]  = '{32'h0000_0073, 32'h0,         3'd0, 4'd9,  5'd0,  5'd0, 5'd0, 1'b0, 5'b10000, 1'b0};
    vt[6]  = '{32'h0010_0073, 32'h0,         3'd0, 4'd9,  5'd0,  5'd0, 5'd0, 1'b0, 5'b01000, 1'b0};
    vt[7]  = '{32'h3020_0073, 32'h0,         3'd0, 4'd9,  5'd0,  5'd0, 5'd0, 1'b0, 5'b00100, 1'b0};
    vt[8]  = '{32'h3052_9073, 32'h0,         3'd0, 4'd9,  5'd0,  5'd5, 5'd0, 1'b0, 5'b00010, 1'b0};
    vt[9]  = '{32'h0000_0000, 32'h0,         3'd0, 4'd15, 5'd0,  5'd0, 5'd0, 1'b0, 5'b00001, 1'b0};
    vt[10] = '{32'h4000_1033, 32'h0,         3'd0, 4'd15, 5'd0,  5'd0, 5'd0, 1'b0, 5'b00001, 1'b0};

    rstn = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(negedge clk); rstn = 1'b1;

    // decode table: load into H, inspect, then consume
    for (int i = 0; i < 11; i++) begin
      push(vt[i].inst, 32'h8000_0000 + 32'(i) * 4);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("v%0d_pc", i), bus.out_pc, 32'h8000_0000 + 32'(i) * 4);
      check($sformatf("v%0d_inst", i), bus.out_inst, vt[i].inst);
      check($sformatf("v%0d_cls", i), 32'(bus.op_class), 32'(vt[i].cls));
      check($sformatf("v%0d_rd", i), 32'(bus.rd), 32'(vt[i].rd));
      check($sformatf("v%0d_rs1", i), 32'(bus.rs1), 32'(vt[i].rs1));
      check($sformatf("v%0d_rs2", i), 32'(bus.rs2), 32'(vt[i].rs2));
      check($sformatf("v%0d_rw", i), 32'(bus.reg_write), 32'(vt[i].rw));
      check($sformatf("v%0d_flags", i),
            32'({bus.is_ecall, bus.is_ebreak, bus.is_mret, bus.is_csr, bus.illegal}),
            32'(vt[i].flg));
      if (vt[i].ci) begin
        check($sformatf("v%0d_imm", i), bus.imm, vt[i].imm);
        check($sformatf("v%0d_ityp", i), 32'(bus.imm_type), 32'(vt[i].ityp));
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check($sformatf("v%0d_drained", i), 32'(bus.out_valid), 32'd0);
    end

    // backpressure: A,B fill both entries, C waits
    push(32'h0010_0013, 32'h100);
    push(32'h0020_0013, 32'h104);
    push(32'h0030_0013, 32'h108);
    check("bp_in_ready_two", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("bp_hold_ready", 32'(bus.in_ready), 32'd0);
    check("bp_head_a", bus.out_inst, 32'h0010_0013);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_head_b", bus.out_inst, 32'h0020_0013);
    check("bp_ready_back", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_head_c", bus.out_inst, 32'h0030_0013);
    check("bp_pc_c", bus.out_pc, 32'h108);
    @(negedge clk);
    check("bp_empty", 32'(bus.out_valid), 32'd0);

    // streaming with out_ready high: output follows input 1 cycle later, no extra bubbles
    pat = 6'b111011;
    pv = 1'b0; pinst = '0;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) begin
        check($sformatf("st%0d_valid", k), 32'(bus.out_valid), 32'(pv));
        if (pv) check($sformatf("st%0d_inst", k), bus.out_inst, pinst);
        check($sformatf("st%0d_ready", k), 32'(bus.in_ready), 32'd1);
      end
      pv = (k < 6) ? pat[k] : 1'b0;
      pinst = 32'h0000_0013 | (32'(k + 1) << 7);
      bus.in_valid = pv;
      bus.in_inst  = pinst;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;

    // flush in TWO with a beat offered
    push(32'h0040_0013, 32'h200);
    push(32'h0050_0013, 32'h204);
    @(negedge clk);
    bus.in_inst = 32'h0060_0013;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; bus.in_valid = 1'b0;
    check("fl2_valid", 32'(bus.out_valid), 32'd0);
    check("fl2_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check("fl2_stays_empty", 32'(bus.out_valid), 32'd0);

    // flush in ONE while a beat is actually accepted: beat dropped
    push(32'h0070_0013, 32'h300);
    @(negedge clk);
    bus.in_inst = 32'h0080_0013;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; bus.in_valid = 1'b0;
    check("fl1_dropped", 32'(bus.out_valid), 32'd0);

    // async reset mid-TWO, observed before the next rising edge
    push(32'h0090_0013, 32'h400);
    push(32'h00A0_0013, 32'h404);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("ar_two_full", 32'(bus.in_ready), 32'd0);
    #2 rstn = 1'b0;
    #1;
    check("ar_out_valid", 32'(bus.out_valid), 32'd0);
    check("ar_in_ready", 32'(bus.in_ready), 32'd1);
    check("ar_inst_clr", bus.out_inst, 32'd0);
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
    check("ar_still_empty", 32'(bus.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
